// File: rtl/wb_intercon_nslave_if.sv
// Wishbone bus bundle for wb_intercon_nslave: master-port signals plus the per-slave fan-out.
// The 'slave' modport is the interconnect's view; the 'master' modport is the system side driving it.
interface wb_intercon_nslave_if #(
   parameter int NUM_SLAVES = 3
);
   logic [31:0]              m_adr_i;
   logic [31:0]              m_dat_i;
   logic [31:0]              m_dat_o;
   logic [3:0]               m_sel_i;
   logic                     m_we_i;
   logic                     m_cyc_i;
   logic                     m_stb_i;
   logic                     m_ack_o;
   logic                     m_err_o;

   logic [31:0]              s_adr_o;
   logic [31:0]              s_dat_o;
   logic [3:0]               s_sel_o;
   logic                     s_we_o;
   logic [NUM_SLAVES-1:0]    s_cyc_o;
   logic [NUM_SLAVES-1:0]    s_stb_o;
   logic [NUM_SLAVES*32-1:0] s_dat_i;
   logic [NUM_SLAVES-1:0]    s_ack_i;
   logic [NUM_SLAVES-1:0]    s_err_i;

   modport slave (
      input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
      input  s_dat_i, s_ack_i, s_err_i
   );

   modport master (
      output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
      input  m_dat_o, m_ack_o, m_err_o,
      input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
      output s_dat_i, s_ack_i, s_err_i
   );
endinterface

// File: rtl/wb_intercon_nslave.sv
// Single-master, N-slave Wishbone classic interconnect with base/mask decode and error status.
// Latency: one registered decode cycle, then slave latency; decode error answers in the 2nd cycle.
// Backpressure: master waits on the selected slave; WB_INTERCON_TIMEOUT_EN adds a watchdog.
module wb_intercon_nslave #(
   parameter int                     NUM_SLAVES = 3,
   parameter logic [NUM_SLAVES*32-1:0] SLV_BASE = {32'h800, 32'h400, 32'h200},
   parameter logic [NUM_SLAVES*32-1:0] SLV_MASK = {32'hFFFFF800, 32'hFFFFFC00, 32'hFFFFFE00},
   parameter int                     TIMEOUT    = 255
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   wb_intercon_nslave_if.slave      bus,
   output logic [1:0]               err_code_o,
   output logic [31:0]              err_adr_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, DERR} state_t;

   state_t                state;
   logic [NUM_SLAVES-1:0] sel_q;
   logic [NUM_SLAVES-1:0] hit;
   logic                  any_hit;
   logic                  m_req;
   logic                  in_access;
   logic                  tmo_expire;
   logic                  live;
   logic                  term_ack;
   logic                  term_err;
   logic                  tmo_err;
   logic [31:0]           rdat;

   assign m_req     = bus.m_cyc_i & bus.m_stb_i;
   assign in_access = (state == ACCESS);

   // Walk from the top slot down so the lowest matching index is the one left standing.
   always_comb begin
      hit = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((bus.m_adr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
            hit    = '0;
            hit[i] = 1'b1;
         end
      end
   end
   assign any_hit = |hit;

`ifdef WB_INTERCON_TIMEOUT_EN
   logic [15:0] timer;

   always_ff @(posedge clk_i) begin
      if (rst_i || state != ACCESS)
         timer <= '0;
      else
         timer <= timer + 16'd1;
   end

   // Strobes drop on the expiry cycle without looking at ack, so a slave whose
   // ack is combinational from stb cannot form a loop back through this logic.
   assign tmo_expire = in_access && (timer == 16'(TIMEOUT));
`else
   assign tmo_expire = 1'b0;
`endif

   assign live          = in_access & bus.m_cyc_i & ~tmo_expire;
   assign bus.s_cyc_o   = live ? sel_q : '0;
   assign bus.s_stb_o   = (live & bus.m_stb_i) ? sel_q : '0;

   assign bus.s_adr_o   = bus.m_adr_i;
   assign bus.s_dat_o   = bus.m_dat_i;
   assign bus.s_sel_o   = bus.m_sel_i;
   assign bus.s_we_o    = bus.m_we_i;

   assign term_ack = in_access & m_req & |(sel_q & bus.s_ack_i);
   assign term_err = in_access & m_req & |(sel_q & bus.s_err_i);
   assign tmo_err  = tmo_expire & bus.m_cyc_i & ~term_ack & ~term_err;

   always_comb begin
      rdat = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (in_access && sel_q[i])
            rdat = rdat | bus.s_dat_i[32*i +: 32];
      end
   end

   assign bus.m_dat_o = rdat;
   assign bus.m_ack_o = term_ack;
   assign bus.m_err_o = term_err | tmo_err | (state == DERR);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         sel_q      <= '0;
         err_code_o <= 2'b00;
         err_adr_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (m_req) begin
                  if (any_hit) begin
                     sel_q <= hit;
                     state <= ACCESS;
                  end else begin
                     err_code_o <= 2'b01;
                     err_adr_o  <= bus.m_adr_i;
                     state      <= DERR;
                  end
               end
            end
            ACCESS: begin
               // Slave errors are only forwarded; the status registers are left alone.
               if (!bus.m_cyc_i || term_ack || term_err) begin
                  sel_q <= '0;
                  state <= IDLE;
               end else if (tmo_expire) begin
                  err_code_o <= 2'b10;
                  err_adr_o  <= bus.m_adr_i;
                  sel_q      <= '0;
                  state      <= IDLE;
               end
            end
            DERR:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/wb_intercon_nslave.md
# wb_intercon_nslave

Parametrised single-master, N-slave Wishbone (classic cycle) interconnect for the MIPS system bus. It sits between the bus_control master port and the memory-mapped slaves (data RAM, GPIO, IOCTRL, and future peripherals), replacing the fixed three-slave intercon. It adds a per-slave base/mask decode table, a registered slave select, a decode-error response for unmapped addresses, an optional bus-timeout watchdog, and a latched error-status report.

## Interface
Parameters:
- NUM_SLAVES, 3, number of slave ports (1..8).
- SLV_BASE, {32'h800, 32'h400, 32'h200}, packed NUM_SLAVES×32 base addresses; slot i = bits [32i+31:32i].
- SLV_MASK, {32'hFFFFF800, 32'hFFFFFC00, 32'hFFFFFE00}, packed NUM_SLAVES×32 decode masks, same slot layout.
- TIMEOUT, 255, cycles in ACCESS before timeout error (1..65535).

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- m_adr_i  in  32  master address.
- m_dat_i  in  32  master write data.
- m_dat_o  out  32  read data to master.
- m_sel_i  in  4  byte selects.
- m_we_i  in  1  write enable.
- m_cyc_i, m_stb_i  in  1 each  master cycle / strobe.
- m_ack_o, m_err_o  out  1 each  termination to master.
- s_adr_o  out  32  address broadcast to all slaves.
- s_dat_o  out  32  write data broadcast.
- s_sel_o  out  4  byte selects broadcast.
- s_we_o  out  1  write enable broadcast.
- s_cyc_o, s_stb_o  out  NUM_SLAVES each  per-slave cycle / strobe, one-hot or zero.
- s_dat_i  in  NUM_SLAVES×32  packed slave read data.
- s_ack_i, s_err_i  in  NUM_SLAVES each  per-slave terminations.
- err_code_o  out  2  last error: 00 none, 01 decode, 10 timeout.
- err_adr_o  out  32  address of last errored cycle.

## Operation
- Decode: slave i matches when (m_adr_i & SLV_MASK[i]) == SLV_BASE[i]; multiple matches → lowest index wins.
- FSM states IDLE, ACCESS, DERR.
- IDLE: m_cyc_i & m_stb_i & match → latch one-hot select reg, clear timer, go ACCESS. No match → latch err_code_o=01, err_adr_o=m_adr_i, go DERR.
- ACCESS: s_cyc_o/s_stb_o = select reg (gated by m_cyc_i/m_stb_i); m_dat_o, m_ack_o, m_err_o combinationally from selected slave. On selected s_ack_i or s_err_i → IDLE next cycle. s_err_i also latches err_code_o=10? No: slave errors forward only, status unchanged.
- DERR: m_err_o=1 for exactly one cycle, m_dat_o=0, no slave strobed; → IDLE.
- Timeout: timer increments each ACCESS cycle; at count == TIMEOUT with no termination → m_err_o=1 that cycle, slave cyc/stb forced 0, err_code_o=10, err_adr_o=m_adr_i, → IDLE.
- Abort: m_cyc_i low in ACCESS → drop slave strobes same cycle, → IDLE, no termination.
- s_adr_o/s_dat_o/s_sel_o/s_we_o = master inputs unregistered.
- Status registers hold until next error or reset.

## Timing
- Reset: state IDLE, select reg 0, timer 0, all s_cyc_o/s_stb_o 0, m_ack_o/m_err_o 0, m_dat_o 0, err_code_o 00, err_adr_o 0.
- Latency: one decode cycle + slave latency; zero-wait slave → m_ack_o in 2nd cycle after stb asserted.
- Decode error: m_err_o in 2nd cycle.
- Back-to-back: strobe held in IDLE after termination starts new decode; min 3 cycles per single-wait transfer.
- rst_i mid-ACCESS: next edge returns to reset values; slave strobes drop.
- Slave ack and timeout same cycle → ack wins, no error recorded.

## Configuration
- WB_INTERCON_TIMEOUT_EN defined: timer and timeout error as above.
- Undefined: no timer logic; ACCESS waits indefinitely; err_code_o never 10.

## Test plan
- Read 0x204, slave0 acks 1 cycle after stb with 0xDEADBEEF → m_ack_o in cycle 2, m_dat_o=0xDEADBEEF, only s_stb_o[0] high.
- Write 0x400 data 0x0000A5A5 sel 4'b0011 → s_stb_o=3'b010, s_dat_o/s_sel_o/s_we_o match, one m_ack_o pulse.
- Access 0x1000 → m_err_o one cycle, no slave strobe, err_code_o=01, err_adr_o=0x1000.
- With macro, TIMEOUT=4, slave2 never acks at 0x800 → m_err_o after 4 ACCESS cycles, strobes drop, err_code_o=10.
- m_cyc_i dropped in ACCESS, then rst_i pulsed mid-access → no termination, all outputs at reset values next cycle.
- Overlapping bases (SLV_BASE all 0x200, masks equal) → only slave0 selected.
